// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies a stable lock, then releases the core reset.
// Define PLL_SEQ_TIMEOUT_EN to retry the PLL reset when lock does not arrive within LOCK_TIMEOUT_CYCLES.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_CYCLES      = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic       lock_lost
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (RELEASE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RELEASE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_PLLRST  = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_RELEASE = CNT_W'(RELEASE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES);

  localparam logic [2:0] ST_PLLRST    = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_QUALIFY   = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             locked_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
`ifdef PLL_SEQ_TIMEOUT_EN
  logic [3:0]       retry_q, retry_d;
`endif

  always_comb begin
    sync1_d = locked;
    sync2_d = sync1_q;
  end

  assign locked_s = sync2_q;

  // Every counted phase loads its length on entry and leaves on the cycle the counter reads 1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LOAD_TIMEOUT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_QUALIFY;
          cnt_d   = LOAD_STABLE;
        end
`ifdef PLL_SEQ_TIMEOUT_EN
        else if (cnt_q <= CNT_ONE) begin
          state_d = ST_PLLRST;
          cnt_d   = LOAD_PLLRST;
          if (retry_q != 4'hF) begin
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      ST_QUALIFY: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LOAD_TIMEOUT;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RELEASE;
          cnt_d   = LOAD_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LOAD_TIMEOUT;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_PLLRST;
          cnt_d       = LOAD_PLLRST;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_PLLRST;
        cnt_d   = LOAD_PLLRST;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d  = (state_d == ST_PLLRST);
    core_rst_d = (state_d != ST_RUN);
    ready_d    = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_PLLRST;
      cnt_q       <= LOAD_PLLRST;
      pll_rst_q   <= 1'b1;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      core_rst_q  <= core_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef PLL_SEQ_TIMEOUT_EN
  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_q <= 4'd0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign retry_count = retry_q;
`else
  assign retry_count = 4'd0;
`endif

  assign pll_rst   = pll_rst_q;
  assign core_rst  = core_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with short parameters (4/8/4/50).
// Directed scenarios plus randomized lock/reset traffic checked against a cycle-level phase model.
module tb_pll_reset_sequencer;

  localparam int P_PLL    = 4;
  localparam int P_STABLE = 8;
  localparam int P_REL    = 4;
  localparam int P_TO     = 50;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic [3:0] retry_count;
  logic       lock_lost;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (P_PLL),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .RELEASE_CYCLES      (P_REL),
    .LOCK_TIMEOUT_CYCLES (P_TO)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .core_rst    (core_rst),
    .ready       (ready),
    .retry_count (retry_count),
    .lock_lost   (lock_lost)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the phase the sequencer is in, how many cycles it has spent there,
  // and the raw lock inputs of the last two edges (the synchronizer delay).
  typedef enum int {M_PLLRST, M_WAIT, M_QUALIFY, M_RELEASE, M_RUN} phase_t;
  phase_t m_phase   = M_PLLRST;
  int     m_elapsed = 0;
  int     m_retries = 0;
  logic   m_lost    = 1'b0;
  logic   m_hist[$];
  int     cycle     = 0;

  // Observation trackers for directed scenarios
  int   pll_high_cnt;
  int   ready_first;
  int   lost_cnt;
  int   lost_at;
  logic lost_core;
  logic lost_pll;
  logic lost_ready;
  int   core_low_seen;
  logic prev_pll;
  int   rise_cycle[$];
  int   rise_retry[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic resetTrackers();
    pll_high_cnt  = 0;
    ready_first   = -1;
    lost_cnt      = 0;
    lost_at       = -1;
    lost_core     = 1'b0;
    lost_pll      = 1'b0;
    lost_ready    = 1'b1;
    core_low_seen = 0;
    prev_pll      = 1'b1;
    rise_cycle.delete();
    rise_retry.delete();
  endtask

  task automatic modelStep(input logic r, input logic l);
    logic ls;
    m_lost = 1'b0;
    if (r) begin
      m_phase   = M_PLLRST;
      m_elapsed = 0;
      m_retries = 0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
      cycle = 0;
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(l);
      cycle++;
      case (m_phase)
        M_PLLRST: begin
          m_elapsed++;
          if (m_elapsed >= P_PLL) begin m_phase = M_WAIT; m_elapsed = 0; end
        end
        M_WAIT: begin
          if (ls) begin
            m_phase = M_QUALIFY; m_elapsed = 0;
          end else begin
`ifdef PLL_SEQ_TIMEOUT_EN
            m_elapsed++;
            if (m_elapsed >= P_TO) begin
              m_phase   = M_PLLRST;
              m_elapsed = 0;
              m_retries = (m_retries < 15) ? m_retries + 1 : 15;
            end
`endif
          end
        end
        M_QUALIFY: begin
          if (!ls) begin
            m_phase = M_WAIT; m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed >= P_STABLE) begin m_phase = M_RELEASE; m_elapsed = 0; end
          end
        end
        M_RELEASE: begin
          if (!ls) begin
            m_phase = M_WAIT; m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed >= P_REL) begin m_phase = M_RUN; m_elapsed = 0; end
          end
        end
        default: begin
          if (!ls) begin m_phase = M_PLLRST; m_elapsed = 0; m_lost = 1'b1; end
        end
      endcase
    end
  endtask

  task automatic checkModel();
    checkOutput("pll_rst",   pll_rst,   m_phase == M_PLLRST);
    checkOutput("core_rst",  core_rst,  m_phase != M_RUN);
    checkOutput("ready",     ready,     m_phase == M_RUN);
    checkOutput("lock_lost", lock_lost, m_lost);
`ifdef PLL_SEQ_TIMEOUT_EN
    checkOutput("retry_count", retry_count, m_retries);
`else
    checkOutput("retry_count", retry_count, 0);
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"},   pll_rst,     1);
    checkOutput({tag, "_core_rst"},  core_rst,    1);
    checkOutput({tag, "_ready"},     ready,       0);
    checkOutput({tag, "_lock_lost"}, lock_lost,   0);
    checkOutput({tag, "_retry"},     retry_count, 0);
  endtask

  // One refclk cycle: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic applyStimulus(input logic r, input logic l);
    rst    = r;
    locked = l;
    @(posedge refclk);
    modelStep(r, l);
    #1;
    checkModel();
    if (pll_rst === 1'b1) pll_high_cnt++;
    if (pll_rst === 1'b1 && prev_pll === 1'b0) begin
      rise_cycle.push_back(cycle);
      rise_retry.push_back(int'(retry_count));
    end
    prev_pll = pll_rst;
    if (ready === 1'b1 && ready_first < 0) ready_first = cycle;
    if (lock_lost === 1'b1) begin
      lost_cnt++;
      if (lost_at < 0) begin
        lost_at    = cycle;
        lost_core  = core_rst;
        lost_pll   = pll_rst;
        lost_ready = ready;
      end
    end
    if (core_rst !== 1'b1) core_low_seen++;
  endtask

  initial begin
    int drop_cycle;
    rst    = 1'b1;
    locked = 1'b0;

    // Bring-up with lock present from the start
    resetTrackers();
    applyStimulus(1'b1, 1'b1);
    checkResetValues("a_reset");
    repeat (30) applyStimulus(1'b0, 1'b1);
    checkOutput("a_pll_rst_cycles", pll_high_cnt, P_PLL);
    checkOutput("a_ready_window",
                (ready_first >= P_PLL + 2 + P_STABLE + P_REL - 1) &&
                (ready_first <= P_PLL + 2 + P_STABLE + P_REL + 1), 1);

    // One-cycle lock glitch sampled at edge 9 reaches locked_s at edge 11, mid-qualification;
    // requalification then starts at edge 12, so RUN comes at 12 + 8 + 4.
    resetTrackers();
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 40; i++) applyStimulus(1'b0, (i != 9));
    checkOutput("b_pll_rst_cycles", pll_high_cnt, P_PLL);
    checkOutput("b_ready_cycle", ready_first, 12 + P_STABLE + P_REL);

    // Lock drops while running
    resetTrackers();
    drop_cycle = cycle + 1;
    for (int i = 1; i <= 12; i++) applyStimulus(1'b0, (i > 3));
    checkOutput("c_lock_lost_pulses", lost_cnt, 1);
    checkOutput("c_lock_lost_delay", lost_at - drop_cycle, 2);
    checkOutput("c_core_rst_at_loss", lost_core, 1);
    checkOutput("c_pll_rst_at_loss", lost_pll, 1);
    checkOutput("c_ready_at_loss", lost_ready, 0);

    // Lock never arrives
    resetTrackers();
    applyStimulus(1'b1, 1'b0);
    repeat (200) applyStimulus(1'b0, 1'b0);
    checkOutput("d_core_rst_held", core_low_seen, 0);
`ifdef PLL_SEQ_TIMEOUT_EN
    checkOutput("d_retry_pulses", rise_cycle.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("d_retry_period", (i < rise_cycle.size()) ? rise_cycle[i] : -1, (i + 1) * (P_PLL + P_TO));
      checkOutput("d_retry_value", (i < rise_retry.size()) ? rise_retry[i] : -1, i + 1);
    end
    repeat (20 * (P_PLL + P_TO)) applyStimulus(1'b0, 1'b0);
    checkOutput("d_retry_saturated", retry_count, 15);
`else
    checkOutput("d_single_pulse", rise_cycle.size(), 0);
    checkOutput("d_pll_rst_cycles", pll_high_cnt, P_PLL);
    checkOutput("d_retry_zero", retry_count, 0);
`endif

    // Reset asserted while in RELEASE (edges 13..16 after reset with lock present)
    resetTrackers();
    applyStimulus(1'b1, 1'b1);
    repeat (15) applyStimulus(1'b0, 1'b1);
    checkOutput("e_before_reset_ready", ready, 0);
    resetTrackers();
    applyStimulus(1'b1, 1'b1);
    checkResetValues("e_reset");
    repeat (25) applyStimulus(1'b0, 1'b1);
    checkOutput("e_pll_rst_cycles", pll_high_cnt, P_PLL);
    checkOutput("e_restart_ready_window",
                (ready_first >= P_PLL + 2 + P_STABLE + P_REL - 1) &&
                (ready_first <= P_PLL + 2 + P_STABLE + P_REL + 1), 1);
    checkOutput("e_no_lock_lost", lost_cnt, 0);

    // Randomized lock runs with occasional reset
    resetTrackers();
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 120; n++) begin
      logic lv;
      int   len;
      lv  = (n % 2 == 0);
      len = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++) applyStimulus(($urandom_range(0, 299) == 0), lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held asserted per attempt (min 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-locked cycles required before release.
REQ-003 SHALL have parameter RELEASE_CYCLES, default 64, cycles between lock qualification and core_rst deassertion.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000, cycles allowed in lock wait before retry (used only with timeout compiled in).
REQ-005 SHALL have port refclk, input, 1, single clock for all logic; free-running 50 MHz reference.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port locked, input, 1, PLL lock flag, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1, drives the PLL reset input.
REQ-009 SHALL have port core_rst, output, 1, active-high reset for downstream logic on the PLL output clocks.
REQ-010 SHALL have port ready, output, 1, high only in RUN.
REQ-011 SHALL have port retry_count, output, 4, saturating count of timeout retries.
REQ-012 SHALL have port lock_lost, output, 1, one-cycle pulse when lock drops in RUN.

Function
REQ-013 SHALL pass locked through a 2-flop synchronizer (locked_s); all decisions use locked_s only, giving 2-cycle input latency.
REQ-014 SHALL implement states PLLRST, WAIT_LOCK, QUALIFY, RELEASE, RUN with one shared down-counter sized for the largest parameter.
REQ-015 PLLRST: pll_rst=1, core_rst=1; after exactly PLL_RST_CYCLES cycles go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0, core_rst=1; on locked_s=1 go to QUALIFY with counter loaded to LOCK_STABLE_CYCLES.
REQ-017 QUALIFY: any cycle with locked_s=0 returns to WAIT_LOCK (no PLL reset, counter reloaded on re-entry); after LOCK_STABLE_CYCLES consecutive high cycles go to RELEASE.
REQ-018 RELEASE: core_rst=1; locked_s=0 returns to WAIT_LOCK; after RELEASE_CYCLES cycles go to RUN.
REQ-019 RUN: core_rst=0, ready=1; locked_s=0 pulses lock_lost for one cycle and enters PLLRST (full re-sequence), core_rst reasserting on the next cycle.
REQ-020 SHALL register all outputs; core_rst deasserts and ready asserts in the same cycle RUN is entered.
REQ-021 retry_count SHALL saturate at 15 and clear only on rst.
REQ-022 lock_lost SHALL not pulse in any state other than RUN.

Reset
REQ-023 While rst=1 on a refclk edge: state=PLLRST, counter=PLL_RST_CYCLES, pll_rst=1, core_rst=1, ready=0, lock_lost=0, retry_count=0, synchronizer flops=0.
REQ-024 rst asserted in any state, including mid-RUN or mid-QUALIFY, SHALL restart the full sequence from PLLRST with no lock_lost pulse.

Configuration
REQ-025 Macro PLL_SEQ_TIMEOUT_EN defined: WAIT_LOCK counts LOCK_TIMEOUT_CYCLES; on expiry without locked_s, increment retry_count and re-enter PLLRST.
REQ-026 Macro PLL_SEQ_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely, LOCK_TIMEOUT_CYCLES ignored, retry_count tied to 0.

Verification
REQ-027 Params 4/8/4/50; rst 1 cycle, locked high from cycle 0 -> pll_rst high exactly 4 cycles, ready and core_rst=0 at cycle 4+2+8+4 ±1 per documented pipeline, never earlier.
REQ-028 locked glitches low 1 cycle midway through QUALIFY -> returns to WAIT_LOCK, pll_rst stays 0, full 8-cycle qualification restarts.
REQ-029 In RUN drop locked -> lock_lost one pulse 2 cycles later, core_rst=1 and pll_rst=1 next cycle, ready=0.
REQ-030 With PLL_SEQ_TIMEOUT_EN, locked held 0 for 200 cycles -> pll_rst re-pulses every 54 cycles, retry_count 1,2,3; held 0 through 20 timeouts -> retry_count saturates at 15.
REQ-031 Without PLL_SEQ_TIMEOUT_EN, locked 0 for 200 cycles -> single pll_rst pulse, retry_count=0, core_rst=1 throughout.
REQ-032 rst asserted during RELEASE -> next cycle all outputs at REQ-023 values, sequence restarts from PLLRST.
